demux_pack2: RTL and testbench
==============================

Name: demux_pack2

Overview:
- Downstream consumer of the 1-to-2 demux (2-bit D, select S, outputs mux_out_1/mux_out_2).
- Per channel, collects SYMS consecutive 2-bit symbols into one packed word.
- Presents completed words on a single valid/ready output port, arbitrating round-robin between the two channels.
- Converts the demux's per-cycle symbol stream into byte-sized words for the next stage.

Parameters:
- DATA_W, 2, symbol width; matches the demux output width.
- SYMS, 4, symbols per packed word; must be ≥ 2.
- OUT_W, DATA_W*SYMS (8), packed word width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  symbol present this cycle.
- in_ready  out  1  block accepts the symbol this cycle.
- S  in  1  demux select: 0 → channel 0, 1 → channel 1.
- mux_out_1  in  DATA_W  channel 0 symbol, from demux.
- mux_out_2  in  DATA_W  channel 1 symbol, from demux.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed word.
- out_ch  out  1  channel the word came from.

Behaviour:
- Reset (async assert, sync release): all accumulators, counters and holding registers cleared; rr_last=1 so channel 0 has first priority.
  - out_valid=0, out_data=0, out_ch=0.
  - in_ready=1 after reset.
- Accept: symbol taken when in_valid && in_ready. Symbol = mux_out_1 if S=0, mux_out_2 if S=1; the other channel's input is ignored.
- Per-channel state:
  - Accumulator acc[c] (OUT_W), count cnt[c] (0..SYMS-1).
  - Holding register hold[c] (OUT_W) with flag hold_v[c].
- Packing order: symbol k of a word goes to bits [k*DATA_W +: DATA_W], so the first symbol lands in the LSBs.
- Word completion: when a symbol is accepted with cnt[c]==SYMS-1:
  - hold[c] <= {symbol, acc[c] upper bits} merged per packing order; hold_v[c] <= 1.
  - acc[c] and cnt[c] cleared.
  - Otherwise cnt[c]++.
- Backpressure: in_ready = !(cnt[S]==SYMS-1 && hold_v[S] && !(hold drained this cycle)).
  - in_ready is combinational on S and the state.
  - A hold register freed in the same cycle may be refilled in that cycle.
- Output stage: one output register (out_valid/out_data/out_ch). State machine OUT_IDLE / OUT_BUSY:
  - OUT_IDLE: if any hold_v set, load the winner into the output register next cycle, clear its hold_v, go to OUT_BUSY.
  - OUT_BUSY: out_valid=1. On out_ready:
    - if another hold_v is pending, reload from it in the same cycle and stay in OUT_BUSY;
    - else go to OUT_IDLE and out_valid=0.
- Arbitration: if both hold_v are set, grant !rr_last; update rr_last on each grant. A single requester wins regardless of rr_last.
- Latency: the last symbol accepted at edge N appears as out_valid=1 after edge N+1 (hold → output), provided the output is free.
- Output stability: out_data and out_ch stay stable while out_valid && !out_ready.
- Each channel holds at most one partial word plus one complete word; the two channels never block each other on input.
- Reset mid-word: partial accumulations are discarded with no output emitted.

Decomposition:
- Package demux_pkg:
  - DATA_W and SYMS defaults.
  - Output FSM state enum {OUT_IDLE, OUT_BUSY}.
  - Channel index constants CH0=0, CH1=1.
- Sub-module pack_lane: one per channel. Contains acc/cnt/hold/hold_v, an accept input and a drain input, and exposes hold and hold_v. Instantiated twice; the top contains the arbiter and output FSM.

Test Plan:
- Reset: assert rst_n=0 mid-stream → out_valid=0, out_data=0, in_ready=1; after release, one further symbol gives no output.
- Single channel: S=0, out_ready=1, symbols 1,2,3,0 → one word out_data=8'h39, out_ch=0, out_valid high 1 cycle after the 4th accept.
- Interleaved channels: S alternating 0/1, D=3 on channel 0 and D=1 on channel 1, 8 symbols → words 8'hFF ch0 and 8'h55 ch1, in completion order.
- Simultaneous pending: out_ready=0, complete both channels → both hold_v set; then release out_ready → ch0 first, then ch1; repeat → ch1 first (round-robin alternates).
- Backpressure: out_ready=0, feed 12 symbols to channel 1 → in_ready drops to 0 at the 12th symbol (output full, hold full, cnt=3); raise out_ready → in_ready=1 the same cycle and no symbol is lost.
- Ignored channel: S=0, mux_out_2=2'b11 held constant → channel 1 word count stays 0 and no out_ch=1 word appears.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared parameters, output FSM states and channel indices for demux_pack2.
package demux_pkg;
    localparam int DATA_W = 2;
    localparam int SYMS   = 4;
    typedef enum logic {OUT_IDLE, OUT_BUSY} out_state_e;
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
endpackage

// File: rtl/pack_lane.sv
// pack_lane: packs SYMS symbols of one channel into a word and parks it in a one-word holding register.
module pack_lane #(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int SYMS   = demux_pkg::SYMS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     accept,
    input  logic [DATA_W-1:0]        sym,
    input  logic                     drain,
    output logic [DATA_W*SYMS-1:0]   hold,
    output logic                     hold_v,
    output logic                     last
);
    localparam int OUT_W = DATA_W * SYMS;
    localparam int CW    = $clog2(SYMS);

    logic [OUT_W-1:0] acc_q, acc_d, hold_q, hold_d, placed;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_v_q, hold_v_d;

    assign last   = cnt_q == CW'(SYMS - 1);
    assign hold   = hold_q;
    assign hold_v = hold_v_q;
    // First symbol of a word lands in the LSBs.
    assign placed = acc_q | (OUT_W'(sym) << (int'(cnt_q) * DATA_W));

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q && !drain;
        if (accept && last) begin
            hold_d   = placed;
            hold_v_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (accept) begin
            acc_d = placed;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end
endmodule

// File: rtl/demux_pack2.sv
// demux_pack2: packs the two demux channels into words and emits them round-robin on one valid/ready port.
module demux_pack2
    import demux_pkg::*;
#(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int SYMS   = demux_pkg::SYMS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     S,
    input  logic [DATA_W-1:0]        mux_out_1,
    input  logic [DATA_W-1:0]        mux_out_2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W*SYMS-1:0]   out_data,
    output logic                     out_ch
);
    localparam int OUT_W = DATA_W * SYMS;

    logic [OUT_W-1:0]  hold [2];
    logic [1:0]        hv, last, drain, accept;
    logic [DATA_W-1:0] sym;
    logic              gnt, load;

    out_state_e        state_q;
    logic              out_valid_q, out_ch_q, rr_last_q;
    logic [OUT_W-1:0]  out_data_q;

    assign sym      = S ? mux_out_2 : mux_out_1;
    // A lane whose hold is being drained this cycle can take its completing symbol.
    assign in_ready = !(last[S] && hv[S] && !drain[S]);
    assign accept[CH0] = in_valid && in_ready && !S;
    assign accept[CH1] = in_valid && in_ready && S;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        pack_lane #(.DATA_W(DATA_W), .SYMS(SYMS)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (accept[i]),
            .sym    (sym),
            .drain  (drain[i]),
            .hold   (hold[i]),
            .hold_v (hv[i]),
            .last   (last[i])
        );
    end

    always_comb begin
        gnt   = (hv == 2'b11) ? !rr_last_q : hv[CH1];
        load  = (state_q == OUT_IDLE || out_ready) && |hv;
        drain = load ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OUT_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= CH0;
            rr_last_q   <= CH1;
        end else if (load) begin
            state_q     <= OUT_BUSY;
            out_valid_q <= 1'b1;
            out_data_q  <= hold[gnt];
            out_ch_q    <= gnt;
            rr_last_q   <= gnt;
        end else if (state_q == OUT_BUSY && out_ready) begin
            state_q     <= OUT_IDLE;
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_demux_pack2.sv
// tb_demux_pack2: directed stimulus against a queue-based model of the packer plus hand-computed word checks.
module tb_demux_pack2;
    localparam int DATA_W = 2;
    localparam int SYMS   = 4;
    localparam int OUT_W  = DATA_W * SYMS;

    logic clk = 0, rst_n = 1, in_valid = 0, S = 0, out_ready = 1;
    logic [DATA_W-1:0] mux_out_1 = 0, mux_out_2 = 0;
    logic in_ready, out_valid, out_ch;
    logic [OUT_W-1:0] out_data;

    int vectors = 0, miscompares = 0;
    bit chk_en = 0;
    logic [OUT_W:0] got[$], exp_q[$];

    demux_pack2 #(.DATA_W(DATA_W), .SYMS(SYMS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .S(S),
        .mux_out_1(mux_out_1), .mux_out_2(mux_out_2), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: per-channel symbol queues, one parked word per channel, one output slot.
    int             m_part [2][$];
    logic [OUT_W-1:0] m_hold [2] = '{default: '0};
    bit             m_hv [2] = '{0, 0};
    bit             m_ov = 0, m_oc = 0, m_rr = 1;
    logic [OUT_W-1:0] m_od = 0;

    function automatic bit m_grant();
        return (m_hv[0] && m_hv[1]) ? !m_rr : m_hv[1];
    endfunction
    function automatic bit m_load();
        return (!m_ov || out_ready) && (m_hv[0] || m_hv[1]);
    endfunction
    function automatic bit m_ready();
        return !(m_part[S].size() == SYMS - 1 && m_hv[S] && !(m_load() && m_grant() == S));
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit take, ld, g;
        int c, w;
        if (!rst_n) begin
            m_part[0].delete(); m_part[1].delete();
            m_hv = '{0, 0}; m_hold = '{default: '0};
            m_ov = 0; m_od = 0; m_oc = 0; m_rr = 1;
        end else begin
            take = in_valid && m_ready();
            ld = m_load();
            g = m_grant();
            c = int'(S);
            if (ld) begin
                m_ov = 1; m_od = m_hold[g]; m_oc = g; m_rr = g; m_hv[g] = 0;
            end else if (m_ov && out_ready) m_ov = 0;
            if (take) begin
                m_part[c].push_back(int'(S ? mux_out_2 : mux_out_1));
                if (m_part[c].size() == SYMS) begin
                    w = 0;
                    foreach (m_part[c][k]) w += m_part[c][k] * (1 << (DATA_W * k));
                    m_hold[c] = OUT_W'(w);
                    m_hv[c] = 1;
                    m_part[c].delete();
                end
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_ch", 32'(out_ch), 32'(m_oc));
        check("in_ready", 32'(in_ready), 32'(m_ready()));
    end

    always @(posedge clk) if (rst_n && out_valid && out_ready) got.push_back({out_ch, out_data});

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic s, input logic [1:0] d, input logic [1:0] other);
        bit rdy = 0;
        in_valid = 1; S = s;
        if (s) begin mux_out_2 = d; mux_out_1 = other; end
        else begin mux_out_1 = d; mux_out_2 = other; end
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk); #2;
        end
        if (!rdy) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1 at %0t", $time);
        end
        in_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle(2); rst_n = 1;
    endtask

    initial begin
        #1 rst_n = 0; chk_en = 1;
        // Reset values
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #2 rst_n = 1;

        // Single channel 1,2,3,0 -> 8'h39 with one-cycle hold-to-output latency
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 0, 0);
        @(negedge clk) check("lat_n", 32'(out_valid), 0);
        @(posedge clk); #2;
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid), 1);
        check("lat_n1_data", 32'(out_data), 32'h39);
        check("lat_n1_ch", 32'(out_ch), 0);
        exp_q.push_back({1'b0, 8'h39});
        idle(3);

        // Interleaved: ch0 all 3, ch1 all 1
        for (int i = 0; i < 8; i++) send(i[0], i[0] ? 2'd1 : 2'd3, 2'd2);
        exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b1, 8'h55});
        idle(4);

        // Ignored channel: mux_out_2 held at 3 while S=0
        for (int i = 0; i < 4; i++) send(0, 2, 3);
        exp_q.push_back({1'b0, 8'hAA});
        idle(4);
        check("ignored_words", 32'(got.size()), 32'(exp_q.size()));

        // Reset mid-word discards the partial word
        send(0, 1, 0); send(0, 1, 0);
        rst_n = 0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_ready", 32'(in_ready), 1);
        @(posedge clk); #2 rst_n = 1;
        send(0, 1, 0);
        idle(6);
        check("midrst_nowords", 32'(got.size()), 32'(exp_q.size()));

        // Round robin, rr_last starts at 1 after reset
        do_reset();
        out_ready = 0;
        send(1, 0, 0); send(1, 1, 0); send(1, 2, 0); send(1, 3, 0);
        for (int i = 0; i < 4; i++) send(0, 3, 0);
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        idle(2);
        out_ready = 1;
        idle(5);
        exp_q.push_back({1'b1, 8'hE4}); exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b1, 8'h55});
        out_ready = 0;
        send(0, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        send(0, 2, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        send(1, 3, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
        idle(2);
        out_ready = 1;
        idle(5);
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b1, 8'h03}); exp_q.push_back({1'b0, 8'h02});

        // Backpressure: 12 symbols to ch1 with output stalled
        out_ready = 0;
        for (int i = 0; i < 11; i++) send(1, 2'(i % 4), 0);
        in_valid = 1; S = 1; mux_out_2 = 3;
        @(negedge clk) check("bp_stall0", 32'(in_ready), 0);
        @(posedge clk); #2;
        @(negedge clk) check("bp_stall1", 32'(in_ready), 0);
        @(posedge clk); #2 out_ready = 1;
        @(negedge clk) check("bp_release", 32'(in_ready), 1);
        @(posedge clk); #2 in_valid = 0;
        idle(8);
        repeat (3) exp_q.push_back({1'b1, 8'hE4});

        check("word_count", 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) check($sformatf("word%0d", i), i < got.size() ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
